control_sequencer: RTL and testbench

Fetch/execute sequencer for the 8-bit datapath: fetches one-byte instructions (plus an optional immediate byte) from program ROM. It generates the load strobes and active-low bus-assert enables consumed by the A/B/X/Q register file and the ALU. It is the producer of the control word whose consumer is the register file, and it owns the program counter and instruction register.

---
 rtl/control_sequencer_pkg.sv | 61 ++++++
 rtl/control_sequencer_checks.sv | 20 ++
 rtl/control_sequencer_decode.sv | 60 ++++++
 rtl/control_sequencer.sv | 97 +++++++++
 tb/tb_control_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the fetch/execute sequencer and the register file that
// consumes its control word.
package control_sequencer_pkg;

  localparam int CLASS_HI = 7;
  localparam int CLASS_LO = 6;
  localparam int SRC_HI   = 5;
  localparam int SRC_LO   = 4;
  localparam int COND_BIT = 3;
  localparam int DST_HI   = 2;
  localparam int DST_LO   = 0;

  localparam logic [1:0] CLASS_MOV = 2'b00;
  localparam logic [1:0] CLASS_HLT = 2'b11;

  localparam logic [1:0] SRC_A   = 2'd0;
  localparam logic [1:0] SRC_X   = 2'd1;
  localparam logic [1:0] SRC_ALU = 2'd2;
  localparam logic [1:0] SRC_IMM = 2'd3;

  localparam logic [2:0] DST_A  = 3'd0;
  localparam logic [2:0] DST_B  = 3'd1;
  localparam logic [2:0] DST_X  = 3'd2;
  localparam logic [2:0] DST_Q  = 3'd3;
  localparam logic [2:0] DST_PC = 3'd4;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Loads first, then the active-low bus asserts.
  typedef struct packed {
    logic loadA;
    logic loadB;
    logic loadX;
    logic loadQ;
    logic assertBarA;
    logic assertBarX;
    logic assertBarAlu;
  } ctrlWord_t;

  localparam int CTRL_W = 7;
  localparam ctrlWord_t CTRL_IDLE = 7'b000_0111;

  function automatic logic [1:0] insClass(input logic [7:0] ins);
    return ins[CLASS_HI:CLASS_LO];
  endfunction

  function automatic logic [1:0] insSrc(input logic [7:0] ins);
    return ins[SRC_HI:SRC_LO];
  endfunction

  function automatic logic insCond(input logic [7:0] ins);
    return ins[COND_BIT];
  endfunction

  function automatic logic [2:0] insDst(input logic [7:0] ins);
    return ins[DST_HI:DST_LO];
  endfunction

endpackage

// File: rtl/control_sequencer_checks.sv
// Safety properties on the sequencer outputs: single bus driver, idle when halted.
module control_sequencer_checks (
  input logic       clk,
  input logic       resetBar,
  input logic       halted,
  input logic [3:0] loads,
  input logic [2:0] assertBars,
  input logic       immDrive
);

  singleDriver: assert property (@(posedge clk) disable iff (!resetBar)
    $countones({~assertBars, immDrive}) <= 1);

  singleLoad: assert property (@(posedge clk) disable iff (!resetBar)
    $onehot0(loads));

  idleWhenHalted: assert property (@(posedge clk) disable iff (!resetBar)
    halted |-> (loads == 4'h0 && assertBars == 3'b111 && !immDrive));

endmodule

// File: rtl/control_sequencer_decode.sv
// Combinational decode of (state, ir, flagZ) into the control word, immediate
// bus drive, PC load and halt request.
module control_sequencer_decode
  import control_sequencer_pkg::*;
(
  input  logic [1:0]        state,
  input  logic [7:0]        ir,
  input  logic              flagZ,
  output logic [CTRL_W-1:0] ctrl,
  output logic              immDrive,
  output logic              pcLoad,
  output logic              haltReq
);

  ctrlWord_t word;
  logic      enable;

  // Decode control outputs; the source assert happens even when cond suppresses the load.
  always_comb begin
    word     = CTRL_IDLE;
    immDrive = 1'b0;
    pcLoad   = 1'b0;
    haltReq  = 1'b0;
    enable   = 1'b0;
    case (state)
      ST_EXEC: begin
        if (insClass(ir) == CLASS_MOV) begin
          enable = !insCond(ir) || flagZ;
          case (insSrc(ir))
            SRC_A:   word.assertBarA   = 1'b0;
            SRC_X:   word.assertBarX   = 1'b0;
            SRC_ALU: word.assertBarAlu = 1'b0;
            SRC_IMM: immDrive          = 1'b1;
            default: word              = CTRL_IDLE;
          endcase
          if (enable) begin
            case (insDst(ir))
              DST_A:   word.loadA = 1'b1;
              DST_B:   word.loadB = 1'b1;
              DST_X:   word.loadX = 1'b1;
              DST_Q:   word.loadQ = 1'b1;
              DST_PC:  pcLoad     = 1'b1;
              default: pcLoad     = 1'b0;
            endcase
          end else begin
            pcLoad = 1'b0;
          end
        end else if (insClass(ir) == CLASS_HLT) begin
          haltReq = 1'b1;
        end else begin
          haltReq = 1'b0;
        end
      end
      default: word = CTRL_IDLE;
    endcase
  end

  assign ctrl = word;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: owns pc, ir and state, and drives the data bus only
// with an immediate byte from program ROM.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       resetBar,
  output logic [7:0] romAddr,
  input  logic [7:0] romData,
  input  logic       flagZ,
  inout  wire  [7:0] dbus,
  output logic       loadA,
  output logic       loadB,
  output logic       loadX,
  output logic       loadQ,
  output logic       assertBarA,
  output logic       assertBarX,
  output logic       assertBarAlu,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic       halted
);

  logic [1:0]        state;
  logic [7:0]        pcReg;
  logic [7:0]        irReg;
  logic [CTRL_W-1:0] ctrlBits;
  ctrlWord_t         ctrlWord;
  logic              immDrive;
  logic              pcLoad;
  logic              haltReq;

  control_sequencer_decode uDecode (
    .state    (state),
    .ir       (irReg),
    .flagZ    (flagZ),
    .ctrl     (ctrlBits),
    .immDrive (immDrive),
    .pcLoad   (pcLoad),
    .haltReq  (haltReq)
  );

  assign ctrlWord     = ctrlBits;
  assign loadA        = ctrlWord.loadA;
  assign loadB        = ctrlWord.loadB;
  assign loadX        = ctrlWord.loadX;
  assign loadQ        = ctrlWord.loadQ;
  assign assertBarA   = ctrlWord.assertBarA;
  assign assertBarX   = ctrlWord.assertBarX;
  assign assertBarAlu = ctrlWord.assertBarAlu;

  // The opcode and its immediate are both read at pc, so the ROM address is just pc.
  assign romAddr = pcReg;
  assign dbus    = immDrive ? romData : 8'hzz;
  assign pc      = pcReg;
  assign ir      = irReg;
  assign halted  = (state == ST_HALT);

  // Sequencer state, program counter and instruction register.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state <= ST_FETCH;
      pcReg <= 8'h00;
      irReg <= 8'h00;
    end else begin
      case (state)
        ST_FETCH: begin
          irReg <= romData;
          pcReg <= pcReg + 8'd1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (pcLoad) begin
            pcReg <= dbus;
          end else if (immDrive) begin
            pcReg <= pcReg + 8'd1;
          end else begin
            pcReg <= pcReg;
          end
          state <= haltReq ? ST_HALT : ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  control_sequencer_checks uChecks (
    .clk        (clk),
    .resetBar   (resetBar),
    .halted     (halted),
    .loads      ({loadQ, loadX, loadB, loadA}),
    .assertBars ({assertBarAlu, assertBarX, assertBarA}),
    .immDrive   (immDrive)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: an instruction-level model pushes expected per-cycle
// observations; a negedge monitor pops and compares them.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       resetBar;
  logic [7:0] romAddr;
  logic [7:0] romData;
  logic       flagZ;
  wire  [7:0] dbus;
  logic       loadA, loadB, loadX, loadQ;
  logic       assertBarA, assertBarX, assertBarAlu;
  logic [7:0] pc, ir;
  logic       halted;

  logic [7:0] rom [256];
  logic [7:0] regA, regX, aluVal;

  assign romData = rom[romAddr];
  // Register file / ALU side of the bus
  assign dbus = !assertBarA ? regA : !assertBarX ? regX : !assertBarAlu ? aluVal : 8'hzz;

  control_sequencer dut (
    .clk          (clk),
    .resetBar     (resetBar),
    .romAddr      (romAddr),
    .romData      (romData),
    .flagZ        (flagZ),
    .dbus         (dbus),
    .loadA        (loadA),
    .loadB        (loadB),
    .loadX        (loadX),
    .loadQ        (loadQ),
    .assertBarA   (assertBarA),
    .assertBarX   (assertBarX),
    .assertBarAlu (assertBarAlu),
    .pc           (pc),
    .ir           (ir),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ir;
    logic [3:0] loads;
    logic [2:0] bars;
    logic       halted;
    logic       dbusChk;
    logic [7:0] dbusVal;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passed = 0;

  logic [7:0] mPc;
  logic [7:0] mIr;
  bit         mHalted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("pc", pc, e.pc);
      check("romAddr", romAddr, e.pc);
      check("ir", ir, e.ir);
      check("loads", {loadQ, loadX, loadB, loadA}, e.loads);
      check("assertBars", {assertBarAlu, assertBarX, assertBarA}, e.bars);
      check("halted", halted, e.halted);
      if (e.dbusChk) check("dbus", dbus, e.dbusVal);
    end
  end

  // Whole-instruction reference: expected FETCH and EXEC observations plus next pc.
  task automatic pushInstr(input bit fz);
    exp_t       f, x;
    logic [7:0] op, immAddr, val, nxt;
    int         src, cond, dst;
    op      = rom[mPc];
    immAddr = mPc + 8'd1;
    f = '{pc: mPc, ir: mIr, loads: 4'h0, bars: 3'b111, halted: 1'b0, dbusChk: 1'b0, dbusVal: 8'h00};
    x = f;
    x.pc = mPc + 8'd1;
    x.ir = op;
    nxt  = mPc + 8'd1;
    if (op < 8'h40) begin
      src  = (op / 16) % 4;
      cond = (op / 8) % 2;
      dst  = op % 8;
      case (src)
        0:       begin val = regA;   x.bars = 3'b110; end
        1:       begin val = regX;   x.bars = 3'b101; end
        2:       begin val = aluVal; x.bars = 3'b011; end
        default: begin val = rom[immAddr]; nxt = mPc + 8'd2; end
      endcase
      x.dbusChk = 1'b1;
      x.dbusVal = val;
      if (cond == 0 || fz) begin
        if (dst < 4) x.loads = 4'(1 << dst);
        if (dst == 4) nxt = val;
      end
    end else if (op >= 8'hC0) begin
      mHalted = 1'b1;
    end
    expQ.push_back(f);
    expQ.push_back(x);
    mIr = op;
    mPc = nxt;
  endtask

  task automatic resetDut();
    resetBar = 1'b0;
    flagZ    = 1'b0;
    @(posedge clk);
    #1;
    check("rstPc", pc, 8'h00);
    check("rstIr", ir, 8'h00);
    check("rstHalted", halted, 1'b0);
    check("rstCtrl", {loadQ, loadX, loadB, loadA, assertBarAlu, assertBarX, assertBarA}, 7'b0000_111);
    expQ.delete();
    mPc      = 8'h00;
    mIr      = 8'h00;
    mHalted  = 1'b0;
    resetBar = 1'b1;
  endtask

  // zMode: 0/1 holds flagZ at that value, 2 randomizes it per instruction.
  task automatic runProgram(input int nInstr, input int zMode);
    bit   fz;
    exp_t h;
    for (int i = 0; i < nInstr && !mHalted; i++) begin
      fz    = (zMode == 2) ? 1'($urandom_range(0, 1)) : 1'(zMode);
      flagZ = fz;
      pushInstr(fz);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
    end
    if (mHalted) begin
      for (int k = 0; k < 10; k++) begin
        h = '{pc: mPc, ir: mIr, loads: 4'h0, bars: 3'b111, halted: 1'b1, dbusChk: 1'b0, dbusVal: 8'h00};
        expQ.push_back(h);
        flagZ = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    #1;
    check("drain", expQ.size(), 0);
  endtask

  task automatic fillRom(input logic [7:0] v);
    for (int a = 0; a < 256; a++) rom[a] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    resetBar = 1'b1;
    flagZ    = 1'b0;
    regA     = 8'hA5;
    regX     = 8'h3C;
    aluVal   = 8'h96;
    fillRom(8'hC0);
    #2 resetBar = 1'b0;

    // MOV IMM->A, then halt
    fillRom(8'hC0);
    rom[0] = 8'h30; rom[1] = 8'h5A;
    resetDut();
    runProgram(4, 2);

    // MOV A->B
    fillRom(8'hC0);
    rom[0] = 8'h01;
    resetDut();
    runProgram(3, 2);

    // conditional IMM->PC, not taken then taken
    fillRom(8'hC0);
    rom[0] = 8'h3C; rom[1] = 8'h10; rom[2] = 8'h02;
    resetDut();
    runProgram(3, 0);
    resetDut();
    runProgram(3, 1);

    // pc wrap: jump to 0xFF, IMM->X whose immediate sits at 0x00
    fillRom(8'hC0);
    rom[0] = 8'h77; rom[1] = 8'h34; rom[2] = 8'hFF; rom[8'hFF] = 8'h32;
    resetDut();
    runProgram(7, 2);

    // HLT, then asynchronous reset without a clock edge
    fillRom(8'hC0);
    resetDut();
    runProgram(2, 0);
    @(negedge clk);
    #2 resetBar = 1'b0;
    #1;
    check("asyncRstPc", pc, 8'h00);
    check("asyncRstHalted", halted, 1'b0);

    // reset in the middle of EXEC of IMM->A
    fillRom(8'hC0);
    rom[0] = 8'h30; rom[1] = 8'h5A;
    resetDut();
    flagZ = 1'b0;
    pushInstr(1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    resetBar = 1'b0;
    #1;
    check("midExecLoadA", loadA, 1'b0);
    check("midExecPc", pc, 8'h00);
    check("midExecDbusFloat", (dbus === 8'h5A), 1'b0);
    resetDut();
    runProgram(3, 0);

    // randomized programs
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
      regA   = 8'($urandom);
      regX   = 8'($urandom);
      aluVal = 8'($urandom);
      resetDut();
      runProgram(30, 2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
